// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversampling rate
// and the counter-width helper used by both UART directions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  function automatic int unsigned os_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side valid/ready holding-register handshake between uart_rx and its consumer.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start/stop validation and a
// valid/ready output holding register with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       baud_tick_os,
  input  logic       rx,
  uart_rx_if.master  rx_if,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned OS_W  = os_cnt_width(OVERSAMPLE);
  localparam int unsigned BIT_W = os_cnt_width(DATA_WIDTH);

  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rx),
    .q      (rx_s)
  );

  uart_state_e           state_q, state_d;
  logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  deliver;

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d  = ST_START;
          os_cnt_d = '0;
        end
      end

      ST_START: begin
        if (baud_tick_os) begin
          if (os_cnt_q == OS_HALF) begin
            if (!rx_s) begin
              state_d   = ST_DATA;
              os_cnt_d  = '0;
              bit_idx_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (baud_tick_os) begin
          if (os_cnt_q == OS_LAST) begin
            shift_d[bit_idx_q] = rx_s;
            os_cnt_d           = '0;
            if (bit_idx_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + BIT_W'(1);
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (baud_tick_os) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (rx_s) begin
              deliver = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A handshake in the delivery cycle frees the register, so the new byte loads instead of overrunning.
    if (deliver) begin
      if (!rx_valid_q || rx_if.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign rx_busy        = (state_q != ST_IDLE);
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of 8N1 frames plus hand-built
// overrun, framing-error, glitch, mid-frame reset and baud-skew sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk

  logic clk = 1'b0;
  logic resetn;
  logic baud_tick_os = 1'b0;
  logic rx;
  logic rx_busy;
  logic frame_err;
  logic overrun;
  int   tick_div = 0;

  uart_rx_if #(.DATA_WIDTH(8)) rif ();

  uart_rx #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .baud_tick_os (baud_tick_os),
    .rx           (rx),
    .rx_if        (rif),
    .rx_busy      (rx_busy),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div     <= (tick_div == 3) ? 0 : tick_div + 1;
    baud_tick_os <= (tick_div == 3);
  end

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int vcyc   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Monitor: samples away from the edge; rx_ready only changes on negedge.
  always @(negedge clk) begin
    #2;
    if (resetn) begin
      if (rif.rx_valid) vcyc++;
      if (rif.rx_valid && rif.rx_ready) obs_q.push_back(rif.rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period);
    rx = 1'b0;
    hold(period);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(period);
    end
    rx = stop_bit;
    hold(period);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (rx_busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, int'(rx_busy), 0);
  endtask

  task automatic drain(input string name);
    check({name, "_sb_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({name, "_sb_data"}, int'(obs_q.pop_front()), int'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic set_ready(input logic r);
    @(negedge clk);
    rif.rx_ready = r;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         period;
    int         exp_hs;
    int         exp_vcyc;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  int v0, f0, o0;
  int hit;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, BIT_CLK,     1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, BIT_CLK,     1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, BIT_CLK,     1, 1, 0};
    vecs[3] = '{8'h5A, 1'b1, BIT_CLK - 2, 1, 1, 0};
    vecs[4] = '{8'h55, 1'b0, BIT_CLK,     0, 0, 1};
    vecs[5] = '{8'hC3, 1'b1, BIT_CLK + 2, 1, 1, 0};

    resetn       = 1'b0;
    rx           = 1'b1;
    rif.rx_ready = 1'b0;
    hold(5);
    check("rst_data",  int'(rif.rx_data), 0);
    check("rst_valid", int'(rif.rx_valid), 0);
    check("rst_busy",  int'(rx_busy), 0);
    check("rst_fe",    int'(frame_err), 0);
    check("rst_ov",    int'(overrun), 0);
    resetn = 1'b1;
    hold(10);

    // Table of single frames with the consumer always ready
    set_ready(1'b1);
    for (int i = 0; i < 6; i++) begin
      v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
      if (vecs[i].exp_hs != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].period);
      hold(8);
      wait_idle($sformatf("vec%0d", i));
      hold(8);
      check($sformatf("vec%0d_vcyc", i), vcyc - v0, vecs[i].exp_vcyc);
      check($sformatf("vec%0d_fe", i), fe_cnt - f0, vecs[i].exp_fe);
      check($sformatf("vec%0d_ov", i), ov_cnt - o0, 0);
      check($sformatf("vec%0d_valid", i), int'(rif.rx_valid), 0);
      drain($sformatf("vec%0d", i));
    end

    // Back-to-back frames, consumer stalled: second byte overruns
    set_ready(1'b0);
    o0 = ov_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b1, BIT_CLK);
    send_frame(8'hC3, 1'b1, BIT_CLK);
    hold(8);
    wait_idle("ovr");
    hold(8);
    check("ovr_count", ov_cnt - o0, 1);
    check("ovr_fe", fe_cnt - f0, 0);
    check("ovr_valid", int'(rif.rx_valid), 1);
    check("ovr_data", int'(rif.rx_data), 'h3C);
    exp_q.push_back(8'h3C);
    set_ready(1'b1);
    hold(4);
    check("ovr_valid_clr", int'(rif.rx_valid), 0);
    drain("ovr");

    // Framing error followed by a long break, then a good frame
    f0 = fe_cnt; v0 = vcyc;
    rx = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;  // 0x55 LSB first
      hold(BIT_CLK);
    end
    rx = 1'b0;
    hold(BIT_CLK * 31);
    check("brk_fe", fe_cnt - f0, 1);
    check("brk_busy", int'(rx_busy), 1);
    check("brk_vcyc", vcyc - v0, 0);
    rx = 1'b1;
    hold(10);
    check("brk_release", int'(rx_busy), 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, BIT_CLK);
    hold(8);
    wait_idle("brk");
    hold(4);
    check("brk_fe_after", fe_cnt - f0, 1);
    drain("brk");

    // Start-bit glitch shorter than half a bit
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    hold(16);
    rx = 1'b1;
    check("glitch_busy_hi", int'(rx_busy), 1);
    hold(100);
    check("glitch_busy_lo", int'(rx_busy), 0);
    check("glitch_events", (vcyc - v0) + (fe_cnt - f0) + (ov_cnt - o0), 0);
    drain("glitch");

    // Reset mid-data of 0xFF, then 0x81
    rx = 1'b0;
    hold(BIT_CLK);
    rx = 1'b1;
    hold(BIT_CLK * 2);
    check("mrst_busy_pre", int'(rx_busy), 1);
    resetn = 1'b0;
    hold(3);
    check("mrst_data",  int'(rif.rx_data), 0);
    check("mrst_valid", int'(rif.rx_valid), 0);
    check("mrst_busy",  int'(rx_busy), 0);
    check("mrst_flags", int'(frame_err) + int'(overrun), 0);
    hold(BIT_CLK * 8);
    resetn = 1'b1;
    hold(10);
    f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_CLK);
    hold(8);
    wait_idle("mrst");
    hold(4);
    check("mrst_flags_after", (fe_cnt - f0) + (ov_cnt - o0), 0);
    drain("mrst");

    // Baud skew, with a handshake landing in the same cycle as a delivery
    set_ready(1'b0);
    o0 = ov_cnt; hit = 0;
    send_frame(8'h96, 1'b1, BIT_CLK + 2);
    hold(8);
    check("skew_first_valid", int'(rif.rx_valid), 1);
    check("skew_first_data", int'(rif.rx_data), 'h96);
    exp_q.push_back(8'h96);
    fork
      send_frame(8'h69, 1'b1, BIT_CLK - 2);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (baud_tick_os && dut.state_q == ST_STOP && dut.os_cnt_q == 4'd15) begin
            rif.rx_ready = 1'b1;
            @(negedge clk);
            rif.rx_ready = 1'b0;
            hit = 1;
            break;
          end
        end
      end
    join
    hold(8);
    check("skew_pulse_hit", hit, 1);
    check("skew_ov", ov_cnt - o0, 0);
    check("skew_valid", int'(rif.rx_valid), 1);
    check("skew_data", int'(rif.rx_data), 'h69);
    exp_q.push_back(8'h69);
    set_ready(1'b1);
    hold(4);
    drain("skew");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
